r_type_sequencer: RTL and testbench
===================================

R_TYPE_SEQUENCER -- requirements
Module: r_type_sequencer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL: in_valid  input  1  instruction offered.
REQ-004 SHALL: in_ready  output  1  sequencer can accept an instruction.
REQ-005 SHALL: instr  input  32  R-type word: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0].
REQ-006 SHALL: rs_addr, rt_addr  output  5 each  register-file read addresses.
REQ-007 SHALL: alu_ctrl  output  6  {ALUOp[5:4], ALU op[3:0]} to the 64-bit ALU.
REQ-008 SHALL: alu_zero, alu_overflow  input  1 each  ALU status flags.
REQ-009 SHALL: wr_en  output  1  register-file write strobe.
REQ-010 SHALL: wr_addr  output  5  register-file write address.
REQ-011 SHALL: done  output  1  one-cycle pulse, instruction retired with write.
REQ-012 SHALL: illegal  output  1  one-cycle pulse, instruction rejected at decode.
REQ-013 SHALL: ovf_trap  output  1  one-cycle pulse, write suppressed on overflow.
REQ-014 SHALL: zero_flag  output  1  alu_zero captured for the last executed instruction.
REQ-015 SHALL: retired_cnt  output  16  count of done pulses.

Function
REQ-016 SHALL: FSM states are IDLE, DECODE, EXEC, WB, ERR.
REQ-017 SHALL: in_ready=1 only in IDLE; handshake is in_valid&&in_ready; instr latched on handshake; IDLE->DECODE.
REQ-018 SHALL: DECODE: opcode must be 0; funct map: 0x20->6'b100010 add, 0x22->6'b100110 sub, 0x24->6'b100000 and, 0x25->6'b100001 or, 0x27->6'b101100 nor, 0x2A->6'b100111 slt.
REQ-019 SHALL: nonzero opcode or unmapped funct -> ERR; ERR asserts illegal for one cycle -> IDLE; no write.
REQ-020 SHALL: legal decode -> EXEC; alu_ctrl, rs_addr, rt_addr registered and held stable through EXEC and WB.
REQ-021 SHALL: EXEC lasts one cycle; alu_zero sampled into zero_flag; alu_overflow sampled for add/sub only; EXEC->WB.
REQ-022 SHALL: WB: wr_addr=rd; wr_en=1 for exactly one cycle unless rd==0 or sampled overflow; then WB->IDLE.
REQ-023 SHALL: WB with rd==0 and no overflow: wr_en=0, done=1, retired_cnt increments.
REQ-024 SHALL: WB with sampled overflow: wr_en=0, ovf_trap=1, done=0, no count.
REQ-025 SHALL: latency: handshake at edge N -> wr_en/done high in cycle N+3 -> in_ready high in cycle N+4; throughput one instruction per 4 cycles.
REQ-026 SHALL: retired_cnt wraps 0xFFFF->0x0000 without flag.
REQ-027 SHALL: in_valid outside IDLE is ignored; instr changes outside the handshake have no effect.
REQ-028 SHALL: done, illegal and ovf_trap are mutually exclusive in any cycle.

Reset
REQ-029 SHALL: rst_n low immediately forces IDLE; in_ready=1; wr_en, done, illegal, ovf_trap, zero_flag=0; rs_addr, rt_addr, wr_addr=0; alu_ctrl=0; retired_cnt=0.
REQ-030 SHALL: reset during EXEC or WB aborts with no write; first handshake allowed on the first rising edge after rst_n deasserts.

Structure
REQ-031 SHALL: opcode/funct codes, the six alu_ctrl encodings and the state enumeration live in shared package r_type_pkg.
REQ-032 SHALL: combinational funct-to-alu_ctrl decoder is one sub-module, rtype_decoder (outputs alu_ctrl and legal).
REQ-033 SHALL: FSM, field registers and counter stay in r_type_sequencer.

Verification
REQ-034 SHALL: add rs=1 rt=2 rd=3 (instr 0x00221820), no overflow -> wr_en=1, wr_addr=3, alu_ctrl=6'b100010 at N+3, done=1, retired_cnt=1.
REQ-035 SHALL: funct 0x3F or opcode 0x23 -> illegal pulse at N+2, no wr_en, in_ready high at N+3, count unchanged.
REQ-036 SHALL: sub rd=5 with alu_overflow=1 in EXEC -> ovf_trap at N+3, wr_en=0, done=0.
REQ-037 SHALL: or rd=0 -> done=1, wr_en=0, retired_cnt increments.
REQ-038 SHALL: in_valid held high for 8 back-to-back legal instructions -> handshakes every 4 cycles, 8 done pulses, in_valid in non-IDLE states ignored.
REQ-039 SHALL: rst_n low during EXEC -> no wr_en, all outputs at reset values; preload retired_cnt to 0xFFFF, retire one -> 0x0000.

Source files
------------

// File: rtl/r_type_pkg.sv
// Shared encodings for the R-type sequencer: instruction fields, opcode/funct
// codes, ALU control words and the sequencer state enumeration.
package r_type_pkg;

  localparam logic [5:0] OPC_RTYPE = 6'h00;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_NOR = 6'h27;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // {ALUOp[5:4], ALU op[3:0]} as consumed by the 64-bit ALU
  localparam logic [5:0] ALU_ADD = 6'b100010;
  localparam logic [5:0] ALU_SUB = 6'b100110;
  localparam logic [5:0] ALU_AND = 6'b100000;
  localparam logic [5:0] ALU_OR  = 6'b100001;
  localparam logic [5:0] ALU_NOR = 6'b101100;
  localparam logic [5:0] ALU_SLT = 6'b100111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_ERR
  } state_e;

  typedef struct packed {
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rtype_t;

  // Only arithmetic ops can trap; logical ops and slt ignore the ALU overflow flag.
  function automatic logic ovf_checked(input logic [5:0] ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/r_type_sequencer_if.sv
// Instruction handshake bundle between an instruction source and the sequencer.
interface r_type_sequencer_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;

  modport master (output in_valid, output instr, input in_ready);
  modport slave  (input in_valid, input instr, output in_ready);
endinterface

// File: rtl/rtype_decoder.sv
// Combinational R-type decoder: maps opcode/funct to an ALU control word and
// flags anything other than the six supported operations as illegal.
module rtype_decoder
  import r_type_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output logic [5:0] alu_ctrl,
  output logic       legal
);

  always_comb begin
    alu_ctrl = '0;
    legal    = 1'b0;
    if (opcode == OPC_RTYPE) begin
      legal = 1'b1;
      case (funct)
        FUNCT_ADD: alu_ctrl = ALU_ADD;
        FUNCT_SUB: alu_ctrl = ALU_SUB;
        FUNCT_AND: alu_ctrl = ALU_AND;
        FUNCT_OR:  alu_ctrl = ALU_OR;
        FUNCT_NOR: alu_ctrl = ALU_NOR;
        FUNCT_SLT: alu_ctrl = ALU_SLT;
        default:   legal    = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/r_type_sequencer.sv
// Four-cycle R-type instruction sequencer: accept, decode, execute on the
// external ALU, then write back (or trap/reject) with registered status pulses.
module r_type_sequencer
  import r_type_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  r_type_sequencer_if.slave   in_if,
  output logic [4:0]          rs_addr,
  output logic [4:0]          rt_addr,
  output logic [5:0]          alu_ctrl,
  input  logic                alu_zero,
  input  logic                alu_overflow,
  output logic                wr_en,
  output logic [4:0]          wr_addr,
  output logic                done,
  output logic                illegal,
  output logic                ovf_trap,
  output logic                zero_flag,
  output logic [15:0]         retired_cnt
);

  state_e      state_q, state_d;
  rtype_t      instr_q, instr_d;
  logic [4:0]  rs_addr_q, rs_addr_d;
  logic [4:0]  rt_addr_q, rt_addr_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [5:0]  alu_ctrl_q, alu_ctrl_d;
  logic        in_ready_q, in_ready_d;
  logic        wr_en_q, wr_en_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        ovf_trap_q, ovf_trap_d;
  logic        zero_flag_q, zero_flag_d;
  logic [15:0] retired_cnt_q, retired_cnt_d;

  logic [5:0]  dec_alu_ctrl;
  logic        dec_legal;
  logic        shamt_unused;

  rtype_decoder u_decoder (
    .opcode   (instr_q.opcode),
    .funct    (instr_q.funct),
    .alu_ctrl (dec_alu_ctrl),
    .legal    (dec_legal)
  );

  // Shift amount is carried in the word but no supported op consumes it.
  assign shamt_unused = ^instr_q.shamt;

  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    rs_addr_d     = rs_addr_q;
    rt_addr_d     = rt_addr_q;
    wr_addr_d     = wr_addr_q;
    alu_ctrl_d    = alu_ctrl_q;
    wr_en_d       = 1'b0;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    ovf_trap_d    = 1'b0;
    zero_flag_d   = zero_flag_q;
    retired_cnt_d = retired_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (in_if.in_valid) begin
          instr_d = in_if.instr;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          rs_addr_d  = instr_q.rs;
          rt_addr_d  = instr_q.rt;
          wr_addr_d  = instr_q.rd;
          alu_ctrl_d = dec_alu_ctrl;
          state_d    = S_EXEC;
        end else begin
          illegal_d = 1'b1;
          state_d   = S_ERR;
        end
      end
      S_EXEC: begin
        // Status pulses are computed here so they are registered into WB.
        zero_flag_d = alu_zero;
        if (alu_overflow && ovf_checked(alu_ctrl_q)) begin
          ovf_trap_d = 1'b1;
        end else begin
          done_d        = 1'b1;
          wr_en_d       = (wr_addr_q != 5'd0);
          retired_cnt_d = retired_cnt_q + 16'd1;
        end
        state_d = S_WB;
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      instr_q       <= '0;
      rs_addr_q     <= '0;
      rt_addr_q     <= '0;
      wr_addr_q     <= '0;
      alu_ctrl_q    <= '0;
      in_ready_q    <= 1'b1;
      wr_en_q       <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      ovf_trap_q    <= 1'b0;
      zero_flag_q   <= 1'b0;
      retired_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      rs_addr_q     <= rs_addr_d;
      rt_addr_q     <= rt_addr_d;
      wr_addr_q     <= wr_addr_d;
      alu_ctrl_q    <= alu_ctrl_d;
      in_ready_q    <= in_ready_d;
      wr_en_q       <= wr_en_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      ovf_trap_q    <= ovf_trap_d;
      zero_flag_q   <= zero_flag_d;
      retired_cnt_q <= retired_cnt_d;
    end
  end

  assign in_if.in_ready = in_ready_q;
  assign rs_addr        = rs_addr_q;
  assign rt_addr        = rt_addr_q;
  assign wr_addr        = wr_addr_q;
  assign alu_ctrl       = alu_ctrl_q;
  assign wr_en          = wr_en_q;
  assign done           = done_q;
  assign illegal        = illegal_q;
  assign ovf_trap       = ovf_trap_q;
  assign zero_flag      = zero_flag_q;
  assign retired_cnt    = retired_cnt_q;

endmodule

// File: tb/tb_r_type_sequencer.sv
// Directed bench for r_type_sequencer with a scoreboard of expected retirements.
module tb_r_type_sequencer;

  localparam int K_DONE = 0;
  localparam int K_ILL  = 1;
  localparam int K_OVF  = 2;

  typedef struct {
    int         kind;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [5:0] alu_ctrl;
    logic       zero;
    int         hs;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        alu_zero;
  logic        alu_overflow;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [5:0]  alu_ctrl;
  logic        wr_en, done, illegal, ovf_trap, zero_flag;
  logic [15:0] retired_cnt;

  r_type_sequencer_if tif ();

  r_type_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_if        (tif),
    .rs_addr      (rs_addr),
    .rt_addr      (rt_addr),
    .alu_ctrl     (alu_ctrl),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .done         (done),
    .illegal      (illegal),
    .ovf_trap     (ovf_trap),
    .zero_flag    (zero_flag),
    .retired_cnt  (retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [15:0] model_cnt = 16'd0;
  logic        model_zero = 1'b0;
  bit          ready_chk = 1'b0;
  int          last_hs = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt, input logic [4:0] rd,
                                     input logic [5:0] fn);
    return {op, rs, rt, rd, 5'd0, fn};
  endfunction

  // Reference decode: {legal, alu_ctrl}
  function automatic logic [6:0] ref_dec(input logic [31:0] w);
    if (w[31:26] != 6'd0) return 7'd0;
    case (w[5:0])
      6'h20:   return {1'b1, 6'b100010};
      6'h22:   return {1'b1, 6'b100110};
      6'h24:   return {1'b1, 6'b100000};
      6'h25:   return {1'b1, 6'b100001};
      6'h27:   return {1'b1, 6'b101100};
      6'h2A:   return {1'b1, 6'b100111};
      default: return 7'd0;
    endcase
  endfunction

  task automatic check_reset_vals(input string tag);
    chk(tag, 64'({tif.in_ready, wr_en, done, illegal, ovf_trap, zero_flag,
                  rs_addr, rt_addr, wr_addr, alu_ctrl, retired_cnt}),
        64'h0000_0400_0000_0000);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (tif.in_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", 64'(tif.in_ready), 64'd1);
  endtask

  task automatic issue(input logic [31:0] w, input logic ovf, input logic zro, input bit hold_valid);
    exp_t       e;
    logic [6:0] d;
    wait_idle();
    tif.in_valid = 1'b1;
    tif.instr    = w;
    alu_overflow = ovf;
    alu_zero     = zro;
    d = ref_dec(w);
    if (!d[6]) e.kind = K_ILL;
    else if (ovf && (d[5:0] == 6'b100010 || d[5:0] == 6'b100110)) e.kind = K_OVF;
    else e.kind = K_DONE;
    e.wr_en    = (e.kind == K_DONE) && (w[15:11] != 5'd0);
    e.wr_addr  = w[15:11];
    e.rs       = w[25:21];
    e.rt       = w[20:16];
    e.alu_ctrl = d[5:0];
    e.zero     = zro;
    e.hs       = cyc + 1;
    last_hs    = e.hs;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (!hold_valid) tif.in_valid = 1'b0;
    tif.instr = $urandom();
  endtask

  task automatic drain();
    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
  endtask

  logic [5:0] fl [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A};

  initial begin
    int prev_hs;
    logic [31:0] w;
    exp_t e;

    rst_n        = 1'b1;
    tif.in_valid = 1'b0;
    tif.instr    = '0;
    alu_zero     = 1'b0;
    alu_overflow = 1'b0;
    #3 rst_n = 1'b0;
    #1 check_reset_vals("reset_vals");

    fork
      forever begin
        @(negedge clk);
        if (rst_n) begin
          chk("excl_pulses", 64'(($countones({done, illegal, ovf_trap}) <= 1) && (!wr_en || done)), 64'd1);
          if (ready_chk) begin
            chk("ready_after", 64'(tif.in_ready), 64'd1);
            ready_chk = 1'b0;
          end
          if (done || illegal || ovf_trap) begin
            if (sb.size() == 0) begin
              chk("unexpected_pulse", 64'({done, illegal, ovf_trap}), 64'd0);
            end else begin
              e = sb.pop_front();
              chk("pulse_kind", 64'({done, illegal, ovf_trap}),
                  (e.kind == K_DONE) ? 64'd4 : (e.kind == K_ILL) ? 64'd2 : 64'd1);
              chk("latency", 64'(cyc - e.hs), (e.kind == K_ILL) ? 64'd1 : 64'd2);
              chk("ready_low", 64'(tif.in_ready), 64'd0);
              if (e.kind != K_ILL) begin
                chk("wr_en", 64'(wr_en), 64'(e.wr_en));
                chk("wr_addr", 64'(wr_addr), 64'(e.wr_addr));
                chk("alu_ctrl", 64'(alu_ctrl), 64'(e.alu_ctrl));
                chk("rs_rt", 64'({rs_addr, rt_addr}), 64'({e.rs, e.rt}));
                model_zero = e.zero;
              end else begin
                chk("ill_no_wr", 64'(wr_en), 64'd0);
              end
              chk("zero_flag", 64'(zero_flag), 64'(model_zero));
              if (e.kind == K_DONE) model_cnt = model_cnt + 16'd1;
              chk("retired_cnt", 64'(retired_cnt), 64'(model_cnt));
              ready_chk = 1'b1;
            end
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Directed single instructions
    issue(32'h0022_1820, 1'b0, 1'b0, 1'b0);               // add rd=3
    issue(mk(6'h00, 5'd1, 5'd2, 5'd3, 6'h3F), 1'b0, 1'b0, 1'b0); // bad funct
    issue(mk(6'h23, 5'd1, 5'd2, 5'd3, 6'h20), 1'b0, 1'b0, 1'b0); // bad opcode
    issue(mk(6'h00, 5'd1, 5'd2, 5'd5, 6'h22), 1'b1, 1'b0, 1'b0); // sub overflow
    issue(mk(6'h00, 5'd1, 5'd2, 5'd0, 6'h25), 1'b0, 1'b1, 1'b0); // or rd=0
    issue(mk(6'h00, 5'd4, 5'd7, 5'd6, 6'h24), 1'b1, 1'b1, 1'b0); // and ignores ovf
    issue(mk(6'h00, 5'd31, 5'd30, 5'd31, 6'h20), 1'b1, 1'b0, 1'b0); // add overflow
    drain();

    // Back-to-back with in_valid held high
    prev_hs = 0;
    for (int i = 0; i < 8; i++) begin
      w = mk(6'h00, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
             5'($urandom_range(0, 31)), fl[i % 6]);
      issue(w, 1'b0, 1'(i % 2), 1'b1);
      if (i > 0) chk("b2b_spacing", 64'(last_hs - prev_hs), 64'd4);
      prev_hs = last_hs;
    end
    tif.in_valid = 1'b0;
    drain();

    // Reset while the instruction is in EXEC
    issue(mk(6'h00, 5'd1, 5'd2, 5'd7, 6'h20), 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("reset_in_exec");
    sb.delete();
    ready_chk  = 1'b0;
    model_cnt  = 16'd0;
    model_zero = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_hold_no_wr", 64'({wr_en, done}), 64'd0);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    issue(mk(6'h00, 5'd2, 5'd3, 5'd8, 6'h2A), 1'b0, 1'b0, 1'b0); // slt just after reset
    drain();

    // Counter wrap from 0xFFFF
    wait_idle();
    force dut.retired_cnt_d = 16'hFFFF;
    @(negedge clk);
    release dut.retired_cnt_d;
    model_cnt = 16'hFFFF;
    #1 chk("preload", 64'(retired_cnt), 64'hFFFF);
    issue(mk(6'h00, 5'd5, 5'd6, 5'd9, 6'h27), 1'b0, 1'b0, 1'b0); // nor, wraps to 0
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
